// File: rtl/simmem_wresp_bank_if.sv
// rtl/simmem_wresp_bank_if.sv - reserve / fill / release handshake bundle of the write-response bank
interface simmem_wresp_bank_if #(
  parameter int Capacity  = 16,
  parameter int RespWidth = 8,
  parameter int IidW      = $clog2(Capacity)
);
  logic                 reserve_valid_i;
  logic                 reserve_ready_o;
  logic [IidW-1:0]      waddr_iid_o;
  logic [RespWidth-1:0] wresp_in_data_i;
  logic                 wresp_in_valid_i;
  logic                 wresp_in_ready_o;
  logic [RespWidth-1:0] wresp_out_data_o;
  logic                 wresp_out_valid_o;
  logic                 wresp_out_ready_i;
  logic [Capacity-1:0]  release_en_onehot_i;
  logic [Capacity-1:0]  released_addr_onehot_o;

  modport master (
    output reserve_valid_i, wresp_in_data_i, wresp_in_valid_i, wresp_out_ready_i, release_en_onehot_i,
    input  reserve_ready_o, waddr_iid_o, wresp_in_ready_o, wresp_out_data_o, wresp_out_valid_o,
           released_addr_onehot_o
  );

  modport slave (
    input  reserve_valid_i, wresp_in_data_i, wresp_in_valid_i, wresp_out_ready_i, release_en_onehot_i,
    output reserve_ready_o, waddr_iid_o, wresp_in_ready_o, wresp_out_data_o, wresp_out_valid_o,
           released_addr_onehot_o
  );
endinterface

// File: rtl/simmem_wresp_bank.sv
// rtl/simmem_wresp_bank.sv - write-response bank: slot reservation, in-order fill, enabled release
// Optional feature macro: SIMMEM_WRESP_BANK_STATS_EN (adds occupancy_o / watermark_o)
module simmem_wresp_bank #(
  parameter int Capacity  = 16,
  parameter int RespWidth = 8,
  parameter int IidW      = $clog2(Capacity)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
`ifdef SIMMEM_WRESP_BANK_STATS_EN
  output logic [IidW:0]   occupancy_o,
  output logic [IidW:0]   watermark_o,
`endif
  simmem_wresp_bank_if.slave bus
);
  localparam logic [1:0] ST_FREE     = 2'd0;
  localparam logic [1:0] ST_RESERVED = 2'd1;
  localparam logic [1:0] ST_FILLED   = 2'd2;

  logic [1:0]           r_state [Capacity];
  logic [RespWidth-1:0] r_data  [Capacity];
  logic [IidW-1:0]      r_fifo  [Capacity];
  logic [IidW-1:0]      r_wptr, r_rptr, r_last_iid, r_out_slot;
  logic [IidW:0]        r_cnt;
  logic                 r_out_valid;
  logic [RespWidth-1:0] r_out_data;

  logic                 w_free_any, w_cand_any, w_res_hs, w_fill_hs, w_out_hs;
  logic [IidW-1:0]      w_free_idx, w_cand_idx, w_head;
  logic [Capacity-1:0]  w_released;

  assign w_out_hs  = r_out_valid & bus.wresp_out_ready_i;
  assign w_res_hs  = bus.reserve_valid_i & w_free_any;
  assign w_fill_hs = bus.wresp_in_valid_i & (r_cnt != '0);
  assign w_head    = r_fifo[r_rptr];

  // Lowest-index FREE slot is the next reservation target; a slot in its release cycle is still FILLED
  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (r_state[i] == ST_FREE) begin
        w_free_any = 1'b1;
        w_free_idx = IidW'(i);
      end
    end
  end

  // Lowest-index FILLED and enabled slot, skipping the one leaving through the output this cycle
  always_comb begin
    w_cand_any = 1'b0;
    w_cand_idx = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (r_state[i] == ST_FILLED && bus.release_en_onehot_i[i] &&
          !(w_out_hs && r_out_slot == IidW'(i))) begin
        w_cand_any = 1'b1;
        w_cand_idx = IidW'(i);
      end
    end
  end

  // One-hot release confirmation, asserted only in the output handshake cycle
  always_comb begin
    w_released = '0;
    for (int i = 0; i < Capacity; i++) begin
      w_released[i] = w_out_hs && (r_out_slot == IidW'(i));
    end
  end

  // Slot life cycle: reserve, fill and release always target distinct slots in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Capacity; i++) r_state[i] <= ST_FREE;
    end else begin
      if (w_res_hs)  r_state[w_free_idx] <= ST_RESERVED;
      if (w_fill_hs) r_state[w_head]     <= ST_FILLED;
      if (w_out_hs)  r_state[r_out_slot] <= ST_FREE;
    end
  end

  // iid FIFO pointers and count; every queued iid owns a slot so the FIFO never overflows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_last_iid <= '0;
    end else begin
      if (w_res_hs)   r_wptr <= r_wptr + 1'b1;
      if (w_fill_hs)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (IidW + 1)'(w_res_hs) - (IidW + 1)'(w_fill_hs);
      if (w_free_any) r_last_iid <= w_free_idx;
    end
  end

  // Payload storage: iid queue entries and response data need no reset
  always_ff @(posedge clk_i) begin
    if (w_res_hs)  r_fifo[r_wptr] <= w_free_idx;
    if (w_fill_hs) r_data[w_head] <= bus.wresp_in_data_i;
  end

  // Registered output stage; held response stays put until its handshake completes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_slot  <= '0;
    end else if (!r_out_valid || w_out_hs) begin
      r_out_valid <= w_cand_any;
      if (w_cand_any) begin
        r_out_data <= r_data[w_cand_idx];
        r_out_slot <= w_cand_idx;
      end
    end
  end

  assign bus.reserve_ready_o        = w_free_any;
  assign bus.waddr_iid_o            = w_free_any ? w_free_idx : r_last_iid;
  assign bus.wresp_in_ready_o       = (r_cnt != '0);
  assign bus.wresp_out_valid_o      = r_out_valid;
  assign bus.wresp_out_data_o       = r_out_data;
  assign bus.released_addr_onehot_o = w_released;

`ifdef SIMMEM_WRESP_BANK_STATS_EN
  logic [IidW:0] r_occ, r_wm, w_occ_next;

  assign w_occ_next = r_occ + (IidW + 1)'(w_res_hs) - (IidW + 1)'(w_out_hs);

  // Non-FREE slot count and its high-water mark; occupancy cannot exceed Capacity
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ <= '0;
      r_wm  <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (w_occ_next > r_wm) r_wm <= w_occ_next;
    end
  end

  assign occupancy_o = r_occ;
  assign watermark_o = r_wm;
`endif
endmodule

// File: tb/tb_simmem_wresp_bank.sv
// tb/tb_simmem_wresp_bank.sv - self-checking bench for simmem_wresp_bank
module tb_simmem_wresp_bank;
  localparam int CAP = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  simmem_wresp_bank_if #(.Capacity(CAP), .RespWidth(8)) bus ();

`ifdef SIMMEM_WRESP_BANK_STATS_EN
  logic [4:0] occupancy;
  logic [4:0] watermark;
  simmem_wresp_bank #(.Capacity(CAP), .RespWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .occupancy_o(occupancy), .watermark_o(watermark), .bus(bus));
`else
  simmem_wresp_bank #(.Capacity(CAP), .RespWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        wv;
    logic [7:0]  wd;
    logic        ordy;
    logic [15:0] en;
    logic        e_rr;
    logic [3:0]  e_iid;
    logic        e_inr;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [15:0] e_rel;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rv, input logic wv, input logic [7:0] wd,
                        input logic ordy, input logic [15:0] en);
    bus.reserve_valid_i     = rv;
    bus.wresp_in_valid_i    = wv;
    bus.wresp_in_data_i     = wd;
    bus.wresp_out_ready_i   = ordy;
    bus.release_en_onehot_i = en;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: slot kinds 0 free, 1 reserved, 2 filled
  int          m_st [CAP];
  logic [7:0]  m_data [CAP];
  int          m_iq [$];
  bit          m_hv;
  int          m_hslot;
  logic [7:0]  m_hdata;
  int          m_wm;

  task automatic model_clear();
    for (int i = 0; i < CAP; i++) m_st[i] = 0;
    m_iq.delete();
    m_hv = 1'b0;
    m_hslot = 0;
    m_hdata = 8'h00;
    m_wm = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    #2;
    do_reset();

    // Reset state
    #1;
    chk("rst_reserve_ready", 32'(bus.reserve_ready_o), 32'd1);
    chk("rst_iid", 32'(bus.waddr_iid_o), 32'd0);
    chk("rst_in_ready", 32'(bus.wresp_in_ready_o), 32'd0);
    chk("rst_out_valid", 32'(bus.wresp_out_valid_o), 32'd0);
    chk("rst_out_data", 32'(bus.wresp_out_data_o), 32'd0);
    chk("rst_released", 32'(bus.released_addr_onehot_o), 32'd0);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_watermark", 32'(watermark), 32'd0);
`endif
    tick();

    // Reserve x3, fill A/B/C, release 2 then 0, empty-FIFO fill attempt, then release 1
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b0, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b1, 4'd2, 1'b1, 1'b0, 8'h00, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, 8'h00, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 8'hB2, 1'b1, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, 8'h00, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, 8'h00, 16'h0000};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0004, 1'b1, 4'd3, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0004, 1'b1, 4'd3, 1'b0, 1'b1, 8'hC3, 16'h0004};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0001, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0001, 1'b1, 4'd2, 1'b0, 1'b1, 8'hA1, 16'h0001};
    tbl[10] = '{1'b0, 1'b1, 8'hEE, 1'b1, 16'h0000, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0002, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0002, 1'b1, 4'd0, 1'b0, 1'b1, 8'hB2, 16'h0002};

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].rv, tbl[i].wv, tbl[i].wd, tbl[i].ordy, tbl[i].en);
      #1;
      chk($sformatf("vec%0d_reserve_ready", i), 32'(bus.reserve_ready_o), 32'(tbl[i].e_rr));
      if (tbl[i].e_rr) chk($sformatf("vec%0d_iid", i), 32'(bus.waddr_iid_o), 32'(tbl[i].e_iid));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.wresp_in_ready_o), 32'(tbl[i].e_inr));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.wresp_out_valid_o), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(bus.wresp_out_data_o), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_released", i), 32'(bus.released_addr_onehot_o), 32'(tbl[i].e_rel));
      tick();
    end

    // Full bank, then release slot 5 and see iid 5 offered one cycle after the pulse
    do_reset();
    for (int i = 0; i < CAP; i++) begin
      set_in(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000);
      #1;
      chk($sformatf("full_iid%0d", i), 32'(bus.waddr_iid_o), 32'(i));
      tick();
    end
    set_in(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000);
    #1;
    chk("full_reserve_ready", 32'(bus.reserve_ready_o), 32'd0);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    chk("full_occupancy", 32'(occupancy), 32'd16);
    chk("full_watermark", 32'(watermark), 32'd16);
`endif
    tick();
    for (int i = 0; i < CAP; i++) begin
      set_in(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 16'h0000);
      #1;
      chk($sformatf("full_fill_ready%0d", i), 32'(bus.wresp_in_ready_o), 32'd1);
      tick();
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 16'h0020);
    #1;
    chk("full_load_valid", 32'(bus.wresp_out_valid_o), 32'd0);
    tick();
    #1;
    chk("full_out_valid", 32'(bus.wresp_out_valid_o), 32'd1);
    chk("full_out_data", 32'(bus.wresp_out_data_o), 32'h45);
    chk("full_released", 32'(bus.released_addr_onehot_o), 32'h0020);
    chk("full_hs_reserve_ready", 32'(bus.reserve_ready_o), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 16'h0000);
    #1;
    chk("full_after_reserve_ready", 32'(bus.reserve_ready_o), 32'd1);
    chk("full_after_iid", 32'(bus.waddr_iid_o), 32'd5);
    chk("full_after_released", 32'(bus.released_addr_onehot_o), 32'd0);
    tick();

    // Output held with ready low for 5 cycles
    do_reset();
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000); tick();
    set_in(1'b0, 1'b1, 8'h5A, 1'b0, 16'h0000); tick();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 16'h0001); tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold%0d_valid", i), 32'(bus.wresp_out_valid_o), 32'd1);
      chk($sformatf("hold%0d_data", i), 32'(bus.wresp_out_data_o), 32'h5A);
      chk($sformatf("hold%0d_released", i), 32'(bus.released_addr_onehot_o), 32'd0);
      if (i == 2) bus.release_en_onehot_i = 16'h0000;
      tick();
    end
    bus.wresp_out_ready_i = 1'b1;
    #1;
    chk("hold_hs_valid", 32'(bus.wresp_out_valid_o), 32'd1);
    chk("hold_hs_released", 32'(bus.released_addr_onehot_o), 32'h0001);
    tick();
    #1;
    chk("hold_after_valid", 32'(bus.wresp_out_valid_o), 32'd0);
    chk("hold_after_released", 32'(bus.released_addr_onehot_o), 32'd0);

    // Slots 1 and 3 released back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin set_in(1'b1, 1'b0, 8'h00, 1'b1, 16'h0000); tick(); end
    for (int i = 0; i < 4; i++) begin set_in(1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 16'h0000); tick(); end
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 16'h000A);
    tick();
    #1;
    chk("b2b_first_data", 32'(bus.wresp_out_data_o), 32'h11);
    chk("b2b_first_released", 32'(bus.released_addr_onehot_o), 32'h0002);
    tick();
    #1;
    chk("b2b_second_valid", 32'(bus.wresp_out_valid_o), 32'd1);
    chk("b2b_second_data", 32'(bus.wresp_out_data_o), 32'h13);
    chk("b2b_second_released", 32'(bus.released_addr_onehot_o), 32'h0008);
    tick();
    #1;
    chk("b2b_after_valid", 32'(bus.wresp_out_valid_o), 32'd0);

    // Reset while a response is held, then same-cycle reserve+fill on an empty FIFO
    do_reset();
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000); tick();
    set_in(1'b0, 1'b1, 8'h77, 1'b0, 16'h0000); tick();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 16'h0001); tick();
    #1;
    chk("mid_rst_pre_valid", 32'(bus.wresp_out_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.wresp_out_valid_o), 32'd0);
    chk("mid_rst_reserve_ready", 32'(bus.reserve_ready_o), 32'd1);
    chk("mid_rst_iid", 32'(bus.waddr_iid_o), 32'd0);
    chk("mid_rst_released", 32'(bus.released_addr_onehot_o), 32'd0);
    do_reset();
    set_in(1'b1, 1'b1, 8'h99, 1'b1, 16'hFFFF);
    #1;
    chk("same_cycle_in_ready", 32'(bus.wresp_in_ready_o), 32'd0);
    tick();
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF);
    #1;
    chk("same_cycle_next_in_ready", 32'(bus.wresp_in_ready_o), 32'd1);
    chk("same_cycle_no_fill_valid", 32'(bus.wresp_out_valid_o), 32'd0);
    tick();
    #1;
    chk("same_cycle_still_no_valid", 32'(bus.wresp_out_valid_o), 32'd0);

    // Randomized traffic against the slot-level reference model
    do_reset();
    model_clear();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int          f;
      int          cand;
      int          occ;
      bit          hs;
      logic        rv, wv, ordy;
      logic [7:0]  wd;
      logic [15:0] en;
      logic [15:0] exp_rel;
      rv   = 1'($urandom_range(0, 1));
      wv   = 1'($urandom_range(0, 1));
      wd   = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      en   = 16'($urandom);
      set_in(rv, wv, wd, ordy, en);
      #1;
      f = -1;
      occ = 0;
      for (int i = CAP - 1; i >= 0; i--) if (m_st[i] == 0) f = i;
      for (int i = 0; i < CAP; i++) if (m_st[i] != 0) occ++;
      if (occ > m_wm) m_wm = occ;
      hs = m_hv && ordy;
      exp_rel = hs ? (16'h0001 << m_hslot) : 16'h0000;
      chk("rnd_reserve_ready", 32'(bus.reserve_ready_o), 32'(f >= 0));
      if (f >= 0) chk("rnd_iid", 32'(bus.waddr_iid_o), 32'(f));
      chk("rnd_in_ready", 32'(bus.wresp_in_ready_o), 32'(m_iq.size() > 0));
      chk("rnd_out_valid", 32'(bus.wresp_out_valid_o), 32'(m_hv));
      if (m_hv) chk("rnd_out_data", 32'(bus.wresp_out_data_o), 32'(m_hdata));
      chk("rnd_released", 32'(bus.released_addr_onehot_o), 32'(exp_rel));
`ifdef SIMMEM_WRESP_BANK_STATS_EN
      chk("rnd_occupancy", 32'(occupancy), 32'(occ));
      chk("rnd_watermark", 32'(watermark), 32'(m_wm));
`endif
      cand = -1;
      for (int i = CAP - 1; i >= 0; i--)
        if (m_st[i] == 2 && en[i] && !(hs && i == m_hslot)) cand = i;
      if (wv && m_iq.size() > 0) begin
        int s;
        s = m_iq.pop_front();
        m_st[s] = 2;
        m_data[s] = wd;
      end
      if (rv && f >= 0) begin
        m_st[f] = 1;
        m_iq.push_back(f);
      end
      if (hs) m_st[m_hslot] = 0;
      if (!m_hv || hs) begin
        m_hv = (cand >= 0);
        if (cand >= 0) begin
          m_hslot = cand;
          m_hdata = m_data[cand];
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
